// File: rtl/sprite_if.sv
// Beam/sprite bus between the sync generator, sprite ROM and the sprite renderer.
// The renderer side uses the slave modport; the driving side uses master.
interface sprite_if #(
    parameter int unsigned POS_W = 9
) ();
    logic             hstart;
    logic             vstart;
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
    logic [7:0]       sprite_x;
    logic [7:0]       sprite_y;
    logic [3:0]       rom_addr;
    logic [7:0]       rom_bits;
    logic             gfx;
    logic             active;

    modport master (
        output hstart, vstart, hpos, vpos, sprite_x, sprite_y, rom_bits,
        input  rom_addr, gfx, active
    );

    modport slave (
        input  hstart, vstart, hpos, vpos, sprite_x, sprite_y, rom_bits,
        output rom_addr, gfx, active
    );
endinterface

// File: rtl/sprite_renderer.sv
// Scanline sprite engine: fetches one bitmap row per line in hblank and shifts it out at sprite_x.
// Define SPRITE_MIRROR_EN for a 16-pixel mirrored draw; otherwise the row is drawn 8 pixels wide.
module sprite_renderer #(
    parameter int unsigned SPRITE_H = 16,
    parameter int unsigned POS_W    = 9
) (
    input logic     clk,
    input logic     reset,
    sprite_if.slave bus
);

`ifdef SPRITE_MIRROR_EN
    localparam int unsigned NPix = 16;
    localparam int unsigned CntW = 5;
`else
    localparam int unsigned NPix = 8;
    localparam int unsigned CntW = 4;
`endif

    typedef enum logic [2:0] {StIdle, StFetch, StLatch, StWaitX, StDraw} state_e;

    state_e            state_q, state_d;
    logic [3:0]        line_q, line_d;
    logic [3:0]        addr_q, addr_d;
    logic [7:0]        row_q, row_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              gfx_q, gfx_d;
    logic              drawn_q, drawn_d;
    logic              pix_cur;
    logic              x_hit;
    logic              y_hit;

    assign x_hit = (bus.hpos == POS_W'(bus.sprite_x));
    assign y_hit = (bus.vpos == POS_W'(bus.sprite_y));

`ifdef SPRITE_MIRROR_EN
    // Second half walks the row backwards: pixel i (8..15) shows row[15-i].
    assign pix_cur = cnt_q[3] ? row_q[3'(~cnt_q[2:0])] : row_q[cnt_q[2:0]];
`else
    assign pix_cur = row_q[cnt_q[2:0]];
`endif

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        addr_d  = addr_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        gfx_d   = 1'b0;
        drawn_d = drawn_q;

        if (bus.vstart) begin
            state_d = StIdle;
            line_d  = 4'd0;
        end else if (bus.hstart && state_q != StIdle) begin
            // New line aborts any unfinished wait/draw.
            if (line_q == 4'(SPRITE_H - 1)) begin
                state_d = StIdle;
            end else begin
                line_d  = line_q + 4'd1;
                addr_d  = line_q + 4'd1;
                drawn_d = 1'b0;
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.hstart && y_hit) begin
                        line_d  = 4'd0;
                        addr_d  = 4'd0;
                        drawn_d = 1'b0;
                        state_d = StFetch;
                    end
                end
                StFetch: state_d = StLatch;
                StLatch: begin
                    row_d   = bus.rom_bits;
                    state_d = StWaitX;
                end
                StWaitX: begin
                    // Pixel 0 is registered on the compare edge so it lands at sprite_x+1.
                    if (!drawn_q && x_hit) begin
                        gfx_d   = row_q[0];
                        cnt_d   = CntW'(1);
                        state_d = StDraw;
                    end
                end
                StDraw: begin
                    if (cnt_q == CntW'(NPix)) begin
                        drawn_d = 1'b1;
                        state_d = StWaitX;
                    end else begin
                        gfx_d = pix_cur;
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            line_q  <= 4'd0;
            addr_q  <= 4'd0;
            row_q   <= 8'd0;
            cnt_q   <= '0;
            gfx_q   <= 1'b0;
            drawn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            gfx_q   <= gfx_d;
            drawn_q <= drawn_d;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.gfx      = gfx_q;
    assign bus.active   = (state_q != StIdle);

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomized bench for sprite_renderer against an event-level model of the sprite timing.
// Honors SPRITE_MIRROR_EN the same way as the design.
module tb_sprite_renderer;

    localparam int HTotal = 100;
    localparam int VTotal = 40;
`ifdef SPRITE_MIRROR_EN
    localparam int NPix = 16;
`else
    localparam int NPix = 8;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_if #(.POS_W(9)) bus ();

    sprite_renderer #(
        .SPRITE_H (16),
        .POS_W    (9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rom_mem [16];
    always_ff @(posedge clk) bus.rom_bits <= rom_mem[bus.rom_addr];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: sprite pixel k of a bitmap row.
    function automatic int ref_pix(input logic [7:0] row, input int k);
`ifdef SPRITE_MIRROR_EN
        if (k < 8) return int'(row[k]);
        return int'(row[15 - k]);
`else
        return int'(row[k]);
`endif
    endfunction

    // Model: timing is tracked as absolute edge numbers rather than states.
    bit m_busy, m_drawing, m_drawn;
    int m_line, m_addr, m_gfx, m_wait_from, m_start;
    int e = 0;
    int gfx_seen = 0, exp_seen = 0;

    task automatic model_reset();
        m_busy = 0; m_drawing = 0; m_drawn = 0;
        m_line = 0; m_addr = 0; m_gfx = 0; m_wait_from = 0; m_start = 0;
    endtask

    task automatic model_edge(input bit hs, input bit vs, input int hp, input int vp,
                              input int sx, input int sy);
        int k;
        if (vs) begin
            m_busy = 0; m_line = 0; m_drawing = 0; m_gfx = 0;
        end else if (hs && m_busy) begin
            m_gfx = 0; m_drawing = 0;
            if (m_line == 15) m_busy = 0;
            else begin
                m_line++; m_addr = m_line; m_wait_from = e + 3; m_drawn = 0;
            end
        end else if (hs && vp == sy) begin
            m_busy = 1; m_line = 0; m_addr = 0; m_wait_from = e + 3; m_drawn = 0; m_gfx = 0;
        end else if (m_busy && m_drawing) begin
            k = e - m_start;
            if (k < NPix) m_gfx = ref_pix(rom_mem[m_line], k);
            else begin
                m_gfx = 0; m_drawing = 0; m_drawn = 1;
            end
        end else if (m_busy && !m_drawn && e >= m_wait_from && hp == sx) begin
            m_drawing = 1; m_start = e; m_gfx = ref_pix(rom_mem[m_line], 0);
        end
        e++;
    endtask

    task automatic run_cycle(input bit hs, input bit vs, input int hp, input int vp);
        @(negedge clk);
        bus.hstart = hs;
        bus.vstart = vs;
        bus.hpos   = 9'(hp);
        bus.vpos   = 9'(vp);
        @(posedge clk);
        model_edge(hs, vs, hp, vp, int'(bus.sprite_x), int'(bus.sprite_y));
        #1;
        check_eq("gfx", int'(bus.gfx), m_gfx);
        check_eq("active", int'(bus.active), int'(m_busy));
        check_eq("rom_addr", int'(bus.rom_addr), m_addr);
        gfx_seen += int'(bus.gfx);
        exp_seen += m_gfx;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        bus.hstart = 1'b0;
        bus.vstart = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rst_gfx", int'(bus.gfx), 0);
        check_eq("rst_active", int'(bus.active), 0);
        check_eq("rst_addr", int'(bus.rom_addr), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int  hs_pos;
        bit  hs, vs;
        bit  pulsed;
        int  sy;
        pulsed = 0;
        reset = 1'b0;
        bus.hstart = 1'b0; bus.vstart = 1'b0;
        bus.hpos = '0; bus.vpos = '0;
        bus.sprite_x = 8'd50; bus.sprite_y = 8'd5;
        for (int i = 0; i < 16; i++) rom_mem[i] = 8'($urandom);
        rom_mem[0] = 8'b00101110;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("init_gfx", int'(bus.gfx), 0);
        check_eq("init_active", int'(bus.active), 0);
        check_eq("init_addr", int'(bus.rom_addr), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int f = 0; f < 7; f++) begin
            hs_pos = 90;
            if (f == 2) begin
                // Late x: compare window opens at hpos 13, sprite_x=5 already passed.
                hs_pos = 10;
                bus.sprite_x = 8'd5;
                bus.sprite_y = 8'd3;
            end else if (f == 4) begin
                bus.sprite_y = 8'd10;
                bus.sprite_x = 8'($urandom_range(0, HTotal - 1));
            end else if (f >= 3) begin
                hs_pos = (f == 5) ? 60 : 40 + 25 * int'($urandom_range(0, 2));
                bus.sprite_x = 8'($urandom_range(0, HTotal - 1));
                bus.sprite_y = 8'($urandom_range(0, VTotal - 1));
            end
            sy = int'(bus.sprite_y);
            for (int vp = 0; vp < VTotal; vp++) begin
                for (int hp = 0; hp < HTotal; hp++) begin
                    hs = (hp == hs_pos);
                    vs = (hp == 0 && vp == 0);
                    if (f == 4 && vp == sy + 8 && hp == hs_pos) vs = 1'b1;
                    if (f >= 3) begin
                        if ($urandom_range(0, 499) == 0) hs = 1'b1;
                        if ($urandom_range(0, 2999) == 0) vs = 1'b1;
                        if ($urandom_range(0, 399) == 0)
                            bus.sprite_x = 8'($urandom_range(0, HTotal - 1));
                    end
                    if (f == 1 && !pulsed && m_gfx == 1) begin
                        reset_pulse();
                        pulsed = 1;
                    end
                    run_cycle(hs, vs, hp, vp);
                end
            end
        end

        check_eq("gfx_count", gfx_seen, exp_seen);
        check_eq("drew_any", int'(gfx_seen > 0), 1);
        check_eq("reset_pulsed", int'(pulsed), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
